smc_counter_lite16: RTL and testbench
=====================================

Name: smc_counter_lite16

Overview:
- Timing-counter stage paired with the SMC16 state machine.
- Captures per-access timing configuration on each valid access.
- Runs the chip-select leading-edge, wait-state and chip-select trailing-edge down-counters that the state machine consumes as r_csle_count16, r_ws_count16 and r_cste_count16.
- Driven by r_smc_currentstate16, smc_nextstate16, valid_access16 and mac_done16; state encodings are the `SMC_* values in smc_defs_lite16.v.

Parameters:
- WS_W, 8, width of wait-state config, store and counter.

Ports:
- sys_clk16  in  1  AHB16 system clock.
- sys_reset16  in  1  asynchronous reset, active high.
- valid_access16  in  1  new access is starting; load config this cycle.
- mac_done16  in  1  last beat of a multiple access.
- r_smc_currentstate16  in  5  registered SMC16 state.
- smc_nextstate16  in  5  next SMC16 state.
- csle_cfg16  in  2  CS leading-edge cycles for the new access.
- cste_cfg16  in  2  CS trailing-edge cycles for the new access.
- oete_cfg16  in  2  read-strobe TE before CS.
- ws_cfg16  in  WS_W  wait-state cycles for the new access.
- r_csle_count16  out  2  CS leading-edge counter.
- r_cste_count16  out  2  CS trailing-edge counter.
- r_ws_count16  out  WS_W  wait-state counter.
- r_csle_store16  out  2  captured csle_cfg16.
- r_cste_store16  out  2  captured cste_cfg16.
- r_oete_store16  out  2  captured oete_cfg16.
- r_ws_store16  out  WS_W  captured ws_cfg16.

Behaviour:
- Reset: all registered outputs are 0, asserted asynchronously on the rising edge of sys_reset16. Outputs hold 0 while reset is high; normal operation resumes on the first clock after deassertion.
- Reset mid-access: all state is discarded; the next access requires a fresh valid_access16.
- Notation: CUR = r_smc_currentstate16, NXT = smc_nextstate16. "src" for a counter means its *_cfg16 input if valid_access16=1, else its store.
- Stores:
  - On a clock with valid_access16=1, all four stores capture their *_cfg16 input.
  - Otherwise the stores hold, including across every beat of a multiple access.
  - Stores update in the same cycle as the counter loads.
- CSLE counter, first matching rule wins:
  - valid_access16: load csle_cfg16.
  - NXT==LE and CUR is RW or FLOAT: load r_csle_store16 (LE re-entry for a later beat).
  - CUR==LE and count!=0: decrement by 1.
  - Otherwise hold.
  - Never decrements below 0.
- WS counter, first matching rule wins:
  - NXT==RW and CUR!=RW: load src.
  - CUR==RW and NXT==RW and count!=0: decrement by 1.
  - CUR==RW and NXT==RW and count==0 (back-to-back beat or access): load src.
  - Otherwise hold.
  - With ws_cfg16=N, RW lasts N+1 cycles per beat.
- CSTE counter, first matching rule wins:
  - valid_access16: load cste_cfg16.
  - CUR==FLOAT and NXT is RW or LE: load r_cste_store16 (next beat).
  - CUR==FLOAT and count!=0: decrement by 1.
  - Otherwise hold.
  - The value is therefore held through STORE, LE and RW, so RW sees the configured value.
- Arithmetic: all counters are unsigned and saturate at 0. A zero config loads 0 and is never decremented.
- Simultaneous events: valid_access16 outranks every other rule on the same edge.
- Illegal encodings: undefined CUR or NXT encodings cause all counters to hold.
- Latency: all outputs are registered, one clock after the triggering inputs.

Test Plan:
1. Reset: assert sys_reset16 mid-clock with counters nonzero -> all outputs 0 immediately; they stay 0 until the first post-release valid_access16.
2. Single read, csle_cfg16=2, ws_cfg16=3, cste_cfg16=1, mac_done16=1:
   - IDLE with valid_access16 -> STORE with csle=2.
   - LE with csle 2->1 -> RW.
   - ws loads 3, then 2, 1, 0 across 4 RW cycles.
   - FLOAT with cste 1->0 -> IDLE.
   - Stores read 2/1/3.
3. Multiple access, mac_done16=0 for two beats, csle_store=1, ws=1:
   - Beat 1 ends RW->LE; csle reloads 1 from store.
   - ws reloads 1 on LE->RW.
   - Stores unchanged across beats.
4. Back-to-back in RW (RW->RW, ws=0, valid_access16=1, ws_cfg16=5) -> ws loads 5 (cfg, not the old store 3); r_ws_store16=5 the same cycle.
5. Zero configs (csle=cste=ws=0): STORE->RW directly; ws=0 for 1 cycle; no FLOAT; counters stay 0, no underflow.
6. valid_access16 coincident with a FLOAT->RW re-entry: csle_cfg16=3 and cste_cfg16=2 load, not the store values.

Source files
------------

// File: rtl/smc_counter_lite16.sv
// smc_counter_lite16: timing-counter stage for the SMC16 state machine.
// Captures per-access timing configuration when an access starts and runs
// the chip-select leading-edge, wait-state and chip-select trailing-edge
// down-counters that the state machine uses to pace its LE, RW and FLOAT
// states. All counters are unsigned and stop at zero.
module smc_counter_lite16 #(
  parameter int WS_W = 8
) (
  input  logic            sys_clk16,
  input  logic            sys_reset16,
  input  logic            valid_access16,
  input  logic            mac_done16,
  input  logic [4:0]      r_smc_currentstate16,
  input  logic [4:0]      smc_nextstate16,
  input  logic [1:0]      csle_cfg16,
  input  logic [1:0]      cste_cfg16,
  input  logic [1:0]      oete_cfg16,
  input  logic [WS_W-1:0] ws_cfg16,
  output logic [1:0]      r_csle_count16,
  output logic [1:0]      r_cste_count16,
  output logic [WS_W-1:0] r_ws_count16,
  output logic [1:0]      r_csle_store16,
  output logic [1:0]      r_cste_store16,
  output logic [1:0]      r_oete_store16,
  output logic [WS_W-1:0] r_ws_store16
);

  // SMC16 state encodings (one-hot, matching the state machine's defines).
  localparam logic [4:0] SMC_IDLE  = 5'b00001;
  localparam logic [4:0] SMC_LE    = 5'b00010;
  localparam logic [4:0] SMC_RW    = 5'b00100;
  localparam logic [4:0] SMC_STORE = 5'b01000;
  localparam logic [4:0] SMC_FLOAT = 5'b10000;

  // Decrement a 2-bit counter, stopping at zero.
  function automatic logic [1:0] dec_sat2(input logic [1:0] v);
    if (v == 2'd0) return 2'd0;
    return v - 2'd1;
  endfunction

  // Decrement the wait-state counter, stopping at zero.
  function automatic logic [WS_W-1:0] dec_sat_ws(input logic [WS_W-1:0] v);
    if (v == '0) return '0;
    return v - WS_W'(1);
  endfunction

  // True for the five defined state encodings only.
  function automatic logic is_legal(input logic [4:0] s);
    case (s)
      SMC_IDLE, SMC_LE, SMC_RW, SMC_STORE, SMC_FLOAT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  logic [4:0]      cur;
  logic [4:0]      nxt;
  logic            states_ok;
  logic [1:0]      csle_src;
  logic [1:0]      cste_src;
  logic [WS_W-1:0] ws_src;
  logic [1:0]      csle_nxt;
  logic [1:0]      cste_nxt;
  logic [WS_W-1:0] ws_nxt;

  // mac_done16 is informational here: beat boundaries are already visible
  // in the CUR/NXT transitions (RW->LE, FLOAT->LE/RW).
  logic unused_mac_done;
  assign unused_mac_done = mac_done16;

  assign cur       = r_smc_currentstate16;
  assign nxt       = smc_nextstate16;
  assign states_ok = is_legal(cur) && is_legal(nxt);

  // Load sources: a starting access uses the live config, later beats use the store.
  always_comb begin
    csle_src = r_csle_store16;
    cste_src = r_cste_store16;
    ws_src   = r_ws_store16;
    if (valid_access16) begin
      csle_src = csle_cfg16;
      cste_src = cste_cfg16;
      ws_src   = ws_cfg16;
    end
  end

  // CS leading-edge counter next value; undefined states freeze it.
  always_comb begin
    csle_nxt = r_csle_count16;
    if (states_ok) begin
      if (valid_access16)
        csle_nxt = csle_cfg16;
      else if ((nxt == SMC_LE) && ((cur == SMC_RW) || (cur == SMC_FLOAT)))
        csle_nxt = r_csle_store16;
      else if (cur == SMC_LE)
        csle_nxt = dec_sat2(r_csle_count16);
    end
  end

  // Wait-state counter next value; a zero count while staying in RW means a
  // back-to-back beat, so it reloads rather than sticking at zero.
  always_comb begin
    ws_nxt = r_ws_count16;
    if (states_ok && (nxt == SMC_RW)) begin
      if (cur != SMC_RW)
        ws_nxt = ws_src;
      else if (r_ws_count16 != '0)
        ws_nxt = dec_sat_ws(r_ws_count16);
      else
        ws_nxt = ws_src;
    end
  end

  // CS trailing-edge counter next value; only FLOAT consumes it, so it is
  // held through STORE, LE and RW.
  always_comb begin
    cste_nxt = r_cste_count16;
    if (states_ok) begin
      if (valid_access16)
        cste_nxt = cste_cfg16;
      else if ((cur == SMC_FLOAT) && ((nxt == SMC_RW) || (nxt == SMC_LE)))
        cste_nxt = r_cste_store16;
      else if (cur == SMC_FLOAT)
        cste_nxt = dec_sat2(r_cste_count16);
    end
  end

  // Configuration stores: capture on access start, hold across all beats.
  always_ff @(posedge sys_clk16 or posedge sys_reset16) begin
    if (sys_reset16) begin
      r_csle_store16 <= '0;
      r_cste_store16 <= '0;
      r_oete_store16 <= '0;
      r_ws_store16   <= '0;
    end else if (valid_access16) begin
      r_csle_store16 <= csle_cfg16;
      r_cste_store16 <= cste_cfg16;
      r_oete_store16 <= oete_cfg16;
      r_ws_store16   <= ws_cfg16;
    end
  end

  // Counter registers.
  always_ff @(posedge sys_clk16 or posedge sys_reset16) begin
    if (sys_reset16) begin
      r_csle_count16 <= '0;
      r_cste_count16 <= '0;
      r_ws_count16   <= '0;
    end else begin
      r_csle_count16 <= csle_nxt;
      r_cste_count16 <= cste_nxt;
      r_ws_count16   <= ws_nxt;
    end
  end

endmodule

// File: tb/tb_smc_counter_lite16.sv
// Directed testbench for smc_counter_lite16: walks the counters through
// single, multiple, back-to-back, zero-config and re-entry accesses, plus
// illegal state encodings and an asynchronous mid-access reset.
module tb_smc_counter_lite16;

  localparam int WS_W = 8;
  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] LE    = 5'b00010;
  localparam logic [4:0] RW    = 5'b00100;
  localparam logic [4:0] STORE = 5'b01000;
  localparam logic [4:0] FLOAT = 5'b10000;

  logic            sys_clk16 = 1'b0;
  logic            sys_reset16;
  logic            valid_access16;
  logic            mac_done16;
  logic [4:0]      r_smc_currentstate16;
  logic [4:0]      smc_nextstate16;
  logic [1:0]      csle_cfg16;
  logic [1:0]      cste_cfg16;
  logic [1:0]      oete_cfg16;
  logic [WS_W-1:0] ws_cfg16;
  logic [1:0]      r_csle_count16;
  logic [1:0]      r_cste_count16;
  logic [WS_W-1:0] r_ws_count16;
  logic [1:0]      r_csle_store16;
  logic [1:0]      r_cste_store16;
  logic [1:0]      r_oete_store16;
  logic [WS_W-1:0] r_ws_store16;

  int total = 0;
  int bad   = 0;

  smc_counter_lite16 #(.WS_W(WS_W)) dut (
    .sys_clk16            (sys_clk16),
    .sys_reset16          (sys_reset16),
    .valid_access16       (valid_access16),
    .mac_done16           (mac_done16),
    .r_smc_currentstate16 (r_smc_currentstate16),
    .smc_nextstate16      (smc_nextstate16),
    .csle_cfg16           (csle_cfg16),
    .cste_cfg16           (cste_cfg16),
    .oete_cfg16           (oete_cfg16),
    .ws_cfg16             (ws_cfg16),
    .r_csle_count16       (r_csle_count16),
    .r_cste_count16       (r_cste_count16),
    .r_ws_count16         (r_ws_count16),
    .r_csle_store16       (r_csle_store16),
    .r_cste_store16       (r_cste_store16),
    .r_oete_store16       (r_oete_store16),
    .r_ws_store16         (r_ws_store16)
  );

  always #5 sys_clk16 = ~sys_clk16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int csle, input int ws, input int cste);
    chk({tag, ".csle"}, 32'(r_csle_count16), 32'(csle));
    chk({tag, ".ws"},   32'(r_ws_count16),   32'(ws));
    chk({tag, ".cste"}, 32'(r_cste_count16), 32'(cste));
  endtask

  task automatic chk_st(input string tag, input int csle, input int cste, input int oete, input int ws);
    chk({tag, ".csle_st"}, 32'(r_csle_store16), 32'(csle));
    chk({tag, ".cste_st"}, 32'(r_cste_store16), 32'(cste));
    chk({tag, ".oete_st"}, 32'(r_oete_store16), 32'(oete));
    chk({tag, ".ws_st"},   32'(r_ws_store16),   32'(ws));
  endtask

  // Apply one cycle of state/config inputs, then sample 1 time unit after the edge.
  task automatic step(input logic va, input logic [4:0] cur, input logic [4:0] nxt,
                      input logic [1:0] csle, input logic [1:0] cste,
                      input logic [1:0] oete, input logic [WS_W-1:0] ws);
    valid_access16       = va;
    r_smc_currentstate16 = cur;
    smc_nextstate16      = nxt;
    csle_cfg16           = csle;
    cste_cfg16           = cste;
    oete_cfg16           = oete;
    ws_cfg16             = ws;
    @(posedge sys_clk16);
    #1;
  endtask

  task automatic go(input logic [4:0] cur, input logic [4:0] nxt);
    step(1'b0, cur, nxt, 2'd0, 2'd0, 2'd0, '0);
  endtask

  initial begin
    sys_reset16 = 1'b1;
    mac_done16  = 1'b1;
    valid_access16 = 1'b0;
    r_smc_currentstate16 = IDLE;
    smc_nextstate16 = IDLE;
    csle_cfg16 = 2'd0; cste_cfg16 = 2'd0; oete_cfg16 = 2'd0; ws_cfg16 = '0;
    repeat (2) @(posedge sys_clk16);
    #1;
    chk_cnt("por", 0, 0, 0);
    chk_st("por", 0, 0, 0, 0);
    sys_reset16 = 1'b0;

    // Single read: csle=2 ws=3 cste=1 oete=2
    step(1'b1, IDLE, STORE, 2'd2, 2'd1, 2'd2, 8'd3);
    chk_cnt("rd.load", 2, 0, 1);
    chk_st("rd.load", 2, 1, 2, 3);
    go(STORE, LE);   chk_cnt("rd.store", 2, 0, 1);
    go(LE, LE);      chk_cnt("rd.le1", 1, 0, 1);
    go(LE, RW);      chk_cnt("rd.le2rw", 0, 3, 1);
    go(RW, RW);      chk_cnt("rd.rw1", 0, 2, 1);
    go(RW, RW);      chk_cnt("rd.rw2", 0, 1, 1);
    go(RW, RW);      chk_cnt("rd.rw3", 0, 0, 1);
    go(RW, FLOAT);   chk_cnt("rd.rw2fl", 0, 0, 1);
    go(FLOAT, IDLE); chk_cnt("rd.float", 0, 0, 0);
    chk_st("rd.end", 2, 1, 2, 3);

    // Multiple access, two beats: csle=1 ws=1 cste=1
    mac_done16 = 1'b0;
    step(1'b1, IDLE, STORE, 2'd1, 2'd1, 2'd0, 8'd1);
    chk_cnt("ma.load", 1, 0, 1);
    go(STORE, LE);   chk_cnt("ma.store", 1, 0, 1);
    go(LE, RW);      chk_cnt("ma.b1le", 0, 1, 1);
    go(RW, RW);      chk_cnt("ma.b1rw", 0, 0, 1);
    go(RW, LE);      chk_cnt("ma.relе", 1, 0, 1);
    chk_st("ma.mid", 1, 1, 0, 1);
    mac_done16 = 1'b1;
    go(LE, RW);      chk_cnt("ma.b2le", 0, 1, 1);
    go(RW, RW);      chk_cnt("ma.b2rw", 0, 0, 1);
    go(RW, FLOAT);   chk_cnt("ma.rw2fl", 0, 0, 1);
    go(FLOAT, IDLE); chk_cnt("ma.float", 0, 0, 0);
    chk_st("ma.end", 1, 1, 0, 1);

    // Back-to-back in RW: old store ws=3, new access ws=5
    step(1'b1, IDLE, STORE, 2'd0, 2'd0, 2'd1, 8'd3);
    chk_cnt("bb.load", 0, 0, 0);
    go(STORE, RW);   chk_cnt("bb.st2rw", 0, 3, 0);
    go(RW, RW);      chk_cnt("bb.rw1", 0, 2, 0);
    go(RW, RW);      chk_cnt("bb.rw2", 0, 1, 0);
    go(RW, RW);      chk_cnt("bb.rw3", 0, 0, 0);
    step(1'b1, RW, RW, 2'd2, 2'd3, 2'd2, 8'd5);
    chk_cnt("bb.new", 2, 5, 3);
    chk_st("bb.new", 2, 3, 2, 5);
    go(RW, RW);      chk_cnt("bb.rw4", 2, 4, 3);

    // Zero configs: STORE->RW directly, no FLOAT, no underflow
    step(1'b1, IDLE, STORE, 2'd0, 2'd0, 2'd0, 8'd0);
    chk_cnt("z.load", 0, 4, 0);
    go(STORE, RW);   chk_cnt("z.st2rw", 0, 0, 0);
    go(RW, IDLE);    chk_cnt("z.rw2id", 0, 0, 0);
    go(LE, LE);      chk_cnt("z.le0", 0, 0, 0);
    go(FLOAT, IDLE); chk_cnt("z.fl0", 0, 0, 0);
    chk_st("z.end", 0, 0, 0, 0);

    // valid_access16 coincident with FLOAT->RW re-entry
    step(1'b1, IDLE, STORE, 2'd1, 2'd1, 2'd0, 8'd0);
    chk_cnt("re.load", 1, 0, 1);
    go(STORE, LE);   chk_cnt("re.store", 1, 0, 1);
    go(LE, RW);      chk_cnt("re.le2rw", 0, 0, 1);
    go(RW, FLOAT);   chk_cnt("re.rw2fl", 0, 0, 1);
    go(FLOAT, FLOAT); chk_cnt("re.fl", 0, 0, 0);
    step(1'b1, FLOAT, RW, 2'd3, 2'd2, 2'd3, 8'd2);
    chk_cnt("re.va", 3, 2, 2);
    chk_st("re.va", 3, 2, 3, 2);

    // Illegal encodings freeze the counters
    go(5'b00011, LE);  chk_cnt("il.cur", 3, 2, 2);
    go(LE, 5'b00000);  chk_cnt("il.nxt", 3, 2, 2);
    go(FLOAT, 5'b11000); chk_cnt("il.fl", 3, 2, 2);
    go(LE, LE);        chk_cnt("il.ok", 2, 2, 2);

    // Asynchronous reset mid-clock with counters nonzero
    #3;
    sys_reset16 = 1'b1;
    #1;
    chk_cnt("rst.async", 0, 0, 0);
    chk_st("rst.async", 0, 0, 0, 0);
    step(1'b1, IDLE, STORE, 2'd3, 2'd3, 2'd3, 8'd7);
    chk_cnt("rst.hold", 0, 0, 0);
    chk_st("rst.hold", 0, 0, 0, 0);
    sys_reset16 = 1'b0;
    go(IDLE, IDLE);  chk_cnt("rst.idle", 0, 0, 0);
    chk_st("rst.idle", 0, 0, 0, 0);
    go(LE, LE);      chk_cnt("rst.le", 0, 0, 0);
    step(1'b1, IDLE, STORE, 2'd2, 2'd1, 2'd1, 8'd6);
    chk_cnt("rst.fresh", 2, 0, 1);
    chk_st("rst.fresh", 2, 1, 1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
